// File: rtl/mem_addr_seq_pkg.sv
// mem_addr_seq_pkg
//   Shared types and constants for the memory-address sequencer.
//   - state_t       : sequencer FSM states
//   - DEF_VEC_BASE  : default address of the first exception-vector byte
//   - DEF_NUM_VEC   : default number of vector bytes / causes
//   - CAUSE_*       : exception cause encodings used by the control unit
//   - clog2_min1()  : index/counter width that never collapses to zero bits
package mem_addr_seq_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ACCESS   = 2'd1,
      EXC_RD   = 2'd2,
      EXC_LOAD = 2'd3
   } state_t;

   localparam int DEF_VEC_BASE = 253;
   localparam int DEF_NUM_VEC  = 3;

   localparam int CAUSE_OPCODE = 0;
   localparam int CAUSE_OVFL   = 1;
   localparam int CAUSE_DIV0   = 2;

   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_wait_cnt.sv
// mem_wait_cnt
//   Loadable down-counter for memory wait states. Loads on 'load',
//   otherwise decrements while nonzero and then parks at zero.
//   Ports:
//     clk      - clock, rising edge
//     reset    - asynchronous active-low reset (count -> 0)
//     load     - load load_val this cycle
//     load_val - value to load
//     zero     - count is zero
module mem_wait_cnt #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] count;

   // NOTE: state registers use non-blocking assignments so every flop
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/mem_addr_seq.sv
// mem_addr_seq
//   Registers one of NUM_SRC address sources, or an exception-vector
//   address (VEC_BASE + cause), onto the memory address bus, sequences the
//   read wait states and returns a one-cycle completion pulse. Exceptions
//   fetch the vector byte and deliver it zero-extended as the new PC.
//   Optional build macro: MEM_ADDR_SEQ_ALIGN_CHECK_EN (word-alignment check
//   on normal requests, adds the align_err output).
//   Ports:
//     clk, reset          - clock (rising) / async active-low reset
//     src_addr, src_sel   - packed address sources and source index
//     word_acc            - 1 = word access, 0 = byte access
//     req_valid/req_ready - normal access handshake (ready only in IDLE)
//     exc_valid/exc_cause - exception request and vector index
//     mem_addr, mem_rd    - registered address and one-cycle read strobe
//     mem_rdata           - vector byte returned by memory
//     rsp_valid           - normal access complete pulse
//     vec_valid, vec_pc   - new-PC pulse and zero-extended vector byte
//     bad_cause           - out-of-range cause, sticky until next accept
//     align_err           - misaligned word access pulse (optional)
module mem_addr_seq
   import mem_addr_seq_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int NUM_SRC  = 5,
   parameter int VEC_BASE = DEF_VEC_BASE,
   parameter int NUM_VEC  = DEF_NUM_VEC,
   parameter int WAIT_CYC = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
   input  logic [clog2_min1(NUM_SRC)-1:0] src_sel,
   input  logic                      word_acc,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      exc_valid,
   input  logic [clog2_min1(NUM_VEC)-1:0] exc_cause,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic                      mem_rd,
   input  logic [7:0]                mem_rdata,
   output logic                      rsp_valid,
   output logic                      vec_valid,
   output logic [ADDR_W-1:0]         vec_pc,
   output logic                      bad_cause
`ifdef MEM_ADDR_SEQ_ALIGN_CHECK_EN
   ,
   output logic                      align_err
`endif
);

   localparam int CNT_W    = clog2_min1(WAIT_CYC + 1);
   localparam int LAST_VEC = NUM_VEC - 1;

   state_t            state, state_nxt;
   logic              accept_req, accept_exc, capture;
   logic              cnt_zero, misalign, cause_bad;
   logic [CNT_W-1:0]  cnt_load_val;
   logic [ADDR_W-1:0] sel_addr, vec_addr;

   // Out-of-range selects fall back to source 0 rather than flagging.
   always_comb begin
      sel_addr = src_addr[ADDR_W-1:0];
      for (int i = 1; i < NUM_SRC; i++) begin
         if (int'(src_sel) == i) sel_addr = src_addr[i*ADDR_W +: ADDR_W];
      end
   end

   // Bad causes are clamped to the last vector byte.
   assign cause_bad = (32'(exc_cause) >= 32'(NUM_VEC));
   assign vec_addr  = ADDR_W'(VEC_BASE) +
                      ADDR_W'(cause_bad ? 32'(LAST_VEC) : 32'(exc_cause));

`ifdef MEM_ADDR_SEQ_ALIGN_CHECK_EN
   assign misalign = word_acc && (sel_addr[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
   logic unused_word_acc;
   assign unused_word_acc = word_acc;
`endif

   // A misaligned access completes immediately, so skip the wait states.
   assign cnt_load_val = misalign ? '0 : CNT_W'(WAIT_CYC);

   mem_wait_cnt #(.W(CNT_W)) u_wait_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (accept_req || accept_exc),
      .load_val (cnt_load_val),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first so no path
   // through the case leaves a variable unassigned (no latch inferred).
   always_comb begin
      state_nxt  = state;
      req_ready  = 1'b0;
      rsp_valid  = 1'b0;
      vec_valid  = 1'b0;
      accept_req = 1'b0;
      accept_exc = 1'b0;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (exc_valid) begin
               accept_exc = 1'b1;
               state_nxt  = EXC_RD;
            end else if (req_valid) begin
               accept_req = 1'b1;
               state_nxt  = ACCESS;
            end
         end
         ACCESS: begin
            if (cnt_zero) begin
               rsp_valid = 1'b1;
               state_nxt = IDLE;
            end
         end
         EXC_RD: begin
            if (cnt_zero) begin
               capture   = 1'b1;
               state_nxt = EXC_LOAD;
            end
         end
         EXC_LOAD: begin
            vec_valid = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_addr  <= '0;
         mem_rd    <= 1'b0;
         vec_pc    <= '0;
         bad_cause <= 1'b0;
      end else begin
         mem_rd <= accept_exc || (accept_req && !misalign);
         if (accept_exc) begin
            mem_addr  <= vec_addr;
            bad_cause <= cause_bad;
         end else if (accept_req) begin
            mem_addr  <= sel_addr;
            bad_cause <= 1'b0;
         end
         if (capture) vec_pc <= ADDR_W'(mem_rdata);
      end
   end

`ifdef MEM_ADDR_SEQ_ALIGN_CHECK_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) align_err <= 1'b0;
      else        align_err <= accept_req && misalign;
   end
`endif

endmodule
